led_pio_fader: RTL and testbench
================================

// Module: led_pio_fader
// PURPOSE
//   Downstream stage of the CPU system's 8-bit LED PIO export. Drives the board LEDs.
//   Turns each PIO bit into a PWM-dimmed LED that fades between off and full-on,
//   so a PIO bit change never produces a hard step in brightness.
//   Per-channel brightness ramp, shared prescaler and PWM counter, registered outputs.
// PARAMETERS
//   N         8     number of LED channels (PIO width)
//   LVL_BITS  4     brightness resolution; MAXL = 2**LVL_BITS-1 = 15
//   PRESCALE  5000  clk cycles per PWM step (>=1); PWM period = MAXL*PRESCALE clks
// PORTS
//   clk      in   1         system clock, same clock as the CPU system
//   rst      in   1         synchronous reset, active-low (0 = reset, sampled on posedge clk)
//   led_in   in   N         LED PIO export from the CPU system (1 = LED requested on)
//   led_out  out  N         to board LED pins, 1 = lit (PWM)
//   busy     out  1         only with LED_FADE_BUSY_EN: some channel is ramping
// BEHAVIOUR
//   Reset (rst==0 at posedge): presc=0, pwm_cnt=0, level[*]=0, tgt_q=0, led_out=0, busy=0.
//   Input: tgt_q <= led_in every clk (1-cycle register; same clock domain, no sync).
//   Prescaler: presc counts 0..PRESCALE-1 and wraps. tick = (presc==PRESCALE-1).
//     PRESCALE=1 gives tick every cycle.
//   PWM: on tick, pwm_cnt counts 0..MAXL-1 and wraps to 0.
//     frame = tick && pwm_cnt==MAXL-1 (end of a PWM period).
//   Per-channel state is derived from level[i] and tgt_q[i]:
//     OFF   level==0, tgt==0           -> UP when tgt==1
//     UP    tgt==1, level<MAXL         -> level+1 on each frame; ON when level reaches MAXL
//     ON    level==MAXL, tgt==1        -> DOWN when tgt==0
//     DOWN  tgt==0, level>0            -> level-1 on each frame; OFF when level reaches 0
//   Reversal mid-ramp (UP<->DOWN) continues from the current level. No jump, no restart.
//   level saturates at 0 and MAXL. The step is +-1 only, so no wrap-around is possible.
//   Output: led_out[i] <= (pwm_cnt < level[i]), registered.
//     level=0 gives constant 0. level=MAXL gives constant 1.
//     Duty cycle = level/MAXL.
//   Latency:
//     led_in change -> tgt_q 1 clk later.
//     First level step at the next frame, then 1 clk to led_out.
//     Full fade = MAXL frames.
//   An input pulse shorter than one frame is still honoured if it is present at the frame edge.
//     Otherwise it is ignored.
//   All channels share presc and pwm_cnt, so they step in the same cycle.
//   Reset asserted mid-ramp clears all state on that edge. Release resumes from OFF.
// CONFIGURATION
//   LED_FADE_BUSY_EN defined:
//     port busy exists.
//     busy <= |(level[i] != (tgt_q[i] ? MAXL : 0)), registered, reset 0.
//   Not defined:
//     no busy port and no busy logic. All other behaviour is identical.
// TESTING (N=8, LVL_BITS=4, PRESCALE=2 => PWM period 30 clks)
//   1. Hold rst=0 for 3 clks with led_in=8'hFF
//      -> led_out=0, level[*]=0 (and busy=0) on every reset edge.
//   2. Release rst, led_in=8'h01
//      -> ch0 level steps 1..15 at successive frames.
//      -> measured duty of ch0 = k/15 per period.
//      -> after 15 frames led_out[0] is constant 1. Other bits stay 0.
//   3. From ch0 at ON, led_in=8'h00
//      -> ch0 ramps 15..0 over 15 frames and ends constant 0.
//   4. led_in=8'h01 until ch0 level=7, then led_in=8'h00
//      -> the next frame gives level 6, no jump. ch0 reaches 0 after 7 frames.
//   5. led_in=8'hA5 mid-ramp of ch0, then rst=0 for 1 clk
//      -> all levels=0 and led_out=0 on the next clk.
//      -> after release, only bits 0,2,5,7 ramp up.
//   6. With LED_FADE_BUSY_EN and led_in toggled 8'h00->8'h80
//      -> busy=1 from 2 clks after the toggle until 1 clk after level[7]=15, then 0.

Source files
------------

// File: rtl/led_pio_fader_if.sv
// LED PIO export bundle: requested LED pattern in, PWM-dimmed LED drive out.
// Optional busy flag present when LED_FADE_BUSY_EN is defined.
interface led_pio_fader_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] led_in;
    logic [N-1:0] led_out;
`ifdef LED_FADE_BUSY_EN
    logic         busy;

    modport master (output led_in, input  led_out, input  busy);
    modport slave  (input  led_in, output led_out, output busy);
`else
    modport master (output led_in, input  led_out);
    modport slave  (input  led_in, output led_out);
`endif
endinterface

// File: rtl/led_pio_fader.sv
// Per-channel LED fader: each PIO bit ramps a PWM brightness level between off and full-on.
// Optional macro LED_FADE_BUSY_EN adds a registered busy flag (some channel still ramping).
module led_pio_fader #(
    parameter int unsigned N        = 8,
    parameter int unsigned LVL_BITS = 4,
    parameter int unsigned PRESCALE = 5000
) (
    input  logic           clk,
    input  logic           rst,
    led_pio_fader_if.slave pio
);
    localparam int unsigned MAXL = (2 ** LVL_BITS) - 1;
    localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_UP,
        CH_ON,
        CH_DOWN
    } ch_state_e;

    logic [PW-1:0]       presc;
    logic [LVL_BITS-1:0] pwm_cnt;
    logic [N-1:0]        tgt_q;
    logic [LVL_BITS-1:0] level [N];
    logic [N-1:0]        led_out_q;

    logic                tick_c;
    logic                frame_c;
    ch_state_e           ch_state_c  [N];
    logic [LVL_BITS-1:0] level_nxt_c [N];
    logic [N-1:0]        led_nxt_c;
    logic                ramping_c;

    // Shared timebase strobes; every channel steps on the same frame.
    assign tick_c  = (presc == PW'(PRESCALE - 1));
    assign frame_c = tick_c && (pwm_cnt == LVL_BITS'(MAXL - 1));

    // Per-channel state decode, next level and next PWM output.
    always_comb begin
        led_nxt_c = '0;
        ramping_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            ch_state_c[i]  = CH_OFF;
            level_nxt_c[i] = level[i];
            led_nxt_c[i]   = (pwm_cnt < level[i]);
            if (tgt_q[i]) begin
                ch_state_c[i] = (level[i] == LVL_BITS'(MAXL)) ? CH_ON : CH_UP;
            end else begin
                ch_state_c[i] = (level[i] == '0) ? CH_OFF : CH_DOWN;
            end
            if ((ch_state_c[i] == CH_UP) || (ch_state_c[i] == CH_DOWN)) begin
                ramping_c = 1'b1;
            end
            if (frame_c) begin
                case (ch_state_c[i])
                    CH_UP:   level_nxt_c[i] = level[i] + LVL_BITS'(1);
                    CH_DOWN: level_nxt_c[i] = level[i] - LVL_BITS'(1);
                    default: level_nxt_c[i] = level[i];
                endcase
            end
        end
    end

    // Timebase, input capture, levels and PWM output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            tgt_q     <= '0;
            led_out_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                level[i] <= '0;
            end
        end else begin
            presc <= tick_c ? '0 : presc + PW'(1);
            if (tick_c) begin
                pwm_cnt <= (pwm_cnt == LVL_BITS'(MAXL - 1)) ? '0 : pwm_cnt + LVL_BITS'(1);
            end
            tgt_q     <= pio.led_in;
            led_out_q <= led_nxt_c;
            for (int i = 0; i < int'(N); i++) begin
                level[i] <= level_nxt_c[i];
            end
        end
    end

    assign pio.led_out = led_out_q;

`ifdef LED_FADE_BUSY_EN
    logic busy_q;

    // A channel in UP or DOWN is exactly one whose level differs from its target end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= ramping_c;
        end
    end

    assign pio.busy = busy_q;
`else
    logic unused_ramping;
    assign unused_ramping = ramping_c;
`endif

endmodule

// File: tb/tb_led_pio_fader.sv
// Testbench for led_pio_fader (N=8, LVL_BITS=4, PRESCALE=2): vector table, hand sequences,
// and randomized input/reset traffic checked every cycle against an arithmetic timebase model.
module tb_led_pio_fader;
    localparam int N    = 8;
    localparam int LB   = 4;
    localparam int P    = 2;
    localparam int MAXL = 15;

    logic clk;
    logic rst;

    led_pio_fader_if #(.N(N)) pio ();

    led_pio_fader #(.N(N), .LVL_BITS(LB), .PRESCALE(P)) dut (
        .clk (clk),
        .rst (rst),
        .pio (pio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: time since reset release drives the PWM phase arithmetically.
    int         m_cyc;
    int         m_lvl [N];
    logic [7:0] m_tgt;
    logic [7:0] m_out;
    logic       m_busy;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  pwm;
        bit  frame;
        if (!rst) begin
            m_cyc  = 0;
            m_tgt  = '0;
            m_out  = '0;
            m_busy = 1'b0;
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
        end else begin
            pwm    = (m_cyc / P) % MAXL;
            frame  = ((m_cyc % (P * MAXL)) == (P * MAXL - 1));
            m_busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_out[i] = (pwm < m_lvl[i]);
                if (m_lvl[i] != (m_tgt[i] ? MAXL : 0)) m_busy = 1'b1;
                if (frame) begin
                    if (m_tgt[i] && m_lvl[i] < MAXL) m_lvl[i] = m_lvl[i] + 1;
                    else if (!m_tgt[i] && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
                end
            end
            m_tgt = pio.led_in;
            m_cyc = m_cyc + 1;
        end
    endtask

    // One clock: update the model with the values sampled at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model_led_out", pio.led_out, m_out);
`ifdef LED_FADE_BUSY_EN
        check("model_busy", 8'(pio.busy), 8'(m_busy));
`endif
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step();
            if (pio.led_out[0]) cnt++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] led_in;
        int         ncyc;
        logic [7:0] exp_out;
        string      name;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst        = 1'b0;
        pio.led_in = 8'hFF;

        vecs[0] = '{1'b0, 8'hFF,   3, 8'h00, "reset_hold"};
        vecs[1] = '{1'b1, 8'h01,  30, 8'h00, "before_first_step"};
        vecs[2] = '{1'b1, 8'h01,   1, 8'h01, "level1_pwm0"};
        vecs[3] = '{1'b1, 8'h01,   2, 8'h00, "level1_pwm1"};
        vecs[4] = '{1'b1, 8'h01, 427, 8'h01, "ch0_full_on"};
        vecs[5] = '{1'b1, 8'h00,  49, 8'h00, "level14_pwm14"};
        vecs[6] = '{1'b1, 8'h00,   2, 8'h01, "level13_pwm0"};
        vecs[7] = '{1'b0, 8'hA5,   1, 8'h00, "reset_mid_ramp"};
        vecs[8] = '{1'b1, 8'hA5,  31, 8'hA5, "a5_first_step"};

        for (int v = 0; v < 9; v++) begin
            rst        = vecs[v].rst;
            pio.led_in = vecs[v].led_in;
            repeat (vecs[v].ncyc) step();
            check(vecs[v].name, pio.led_out, vecs[v].exp_out);
        end

        // Reversal at level 7: steps down from 7 with no jump, reaches 0 after 7 frames.
        rst = 1'b0;
        step();
        rst        = 1'b1;
        pio.led_in = 8'h01;
        repeat (210) step();
        pio.led_in = 8'h00;
        count_high(30, cnt);
        check("rev_duty7", 8'(cnt), 8'd14);
        count_high(30, cnt);
        check("rev_duty6", 8'(cnt), 8'd12);
        repeat (120) step();
        count_high(30, cnt);
        check("rev_duty1", 8'(cnt), 8'd2);
        count_high(30, cnt);
        check("rev_duty0", 8'(cnt), 8'd0);

`ifdef LED_FADE_BUSY_EN
        rst = 1'b0;
        step();
        check("busy_reset", 8'(pio.busy), 8'd0);
        rst        = 1'b1;
        pio.led_in = 8'h80;
        step();
        check("busy_clk1", 8'(pio.busy), 8'd0);
        step();
        check("busy_clk2", 8'(pio.busy), 8'd1);
        repeat (448) step();
        check("busy_at_full", 8'(pio.busy), 8'd1);
        step();
        check("busy_clear", 8'(pio.busy), 8'd0);
        check("busy_led7_on", pio.led_out, 8'h80);
`endif

        // Randomized pattern changes, short pulses and occasional reset pulses.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b1;
            end
            pio.led_in = 8'($urandom);
            repeat ($urandom_range(1, 120)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
